// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller and its helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_e;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;
    localparam int unsigned KP_KEYS = 16;

    localparam int unsigned ROW_W  = 2;
    localparam int unsigned COL_W  = 2;
    localparam int unsigned CODE_W = 4;

    localparam logic [KP_ROWS-1:0] ROW_IDLE = 4'hF;

    function automatic logic one_row_low(input logic [KP_ROWS-1:0] rows);
        return $countones(~rows) == 1;
    endfunction

    function automatic logic [ROW_W-1:0] low_row_idx(input logic [KP_ROWS-1:0] rows);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < KP_ROWS; i++) begin
            if (!rows[i]) idx = ROW_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_scan_tick_gen.sv
// Free-running clock divider: one-cycle tick every DIV clocks (count DIV-1).
module scan_tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick_o = (cnt_q == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner with press/release debounce and one-hot key output.
// Optional auto-repeat of key_valid while held: define KEY_REPEAT_EN.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 10,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_RATE    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KP_ROWS-1:0] row_n,
    output logic [KP_COLS-1:0] col_n,
    output logic [KP_KEYS-1:0] onehot,
    output logic               key_valid,
    output logic               key_held
);

    if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("keypad_scan_ctrl: illegal parameter value");
    end

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [KP_ROWS-1:0] row_meta_q, row_s_q;
    logic               tick;
    state_e             state_q;
    logic [COL_W-1:0]   col_idx_q;
    logic [CODE_W-1:0]  code_q;
    logic [DEB_W-1:0]   deb_cnt_q, rel_cnt_q;
    logic [KP_KEYS-1:0] onehot_q;
    logic               valid_q, held_q;
    logic [KP_ROWS-1:0] cap_pat;

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic             rpt_phase_q;
    logic [RPT_W-1:0] rpt_last;

    // First repeat after REPEAT_DELAY ticks, then one every REPEAT_RATE ticks.
    assign rpt_last = rpt_phase_q ? RPT_W'(REPEAT_RATE - 1) : RPT_W'(REPEAT_DELAY - 1);
`endif

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= ROW_IDLE;
            row_s_q    <= ROW_IDLE;
        end else begin
            row_meta_q <= row_n;
            row_s_q    <= row_meta_q;
        end
    end

    // Row pattern expected while the captured key is the only one pressed.
    assign cap_pat = ~(KP_ROWS'(1) << code_q[CODE_W-1 -: ROW_W]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            col_idx_q   <= '0;
            code_q      <= '0;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            onehot_q    <= '0;
            valid_q     <= 1'b0;
            held_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    SCAN: begin
                        if (one_row_low(row_s_q)) begin
                            code_q    <= {low_row_idx(row_s_q), col_idx_q};
                            deb_cnt_q <= '0;
                            state_q   <= DEBOUNCE;
                        end else begin
                            col_idx_q <= col_idx_q + 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (row_s_q == cap_pat) begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                            if (deb_cnt_q == DEB_W'(DEBOUNCE_SCANS - 1)) begin
                                onehot_q    <= KP_KEYS'(1) << code_q;
                                held_q      <= 1'b1;
                                valid_q     <= 1'b1;
                                rel_cnt_q   <= '0;
                                state_q     <= HELD;
`ifdef KEY_REPEAT_EN
                                rpt_cnt_q   <= '0;
                                rpt_phase_q <= 1'b0;
`endif
                            end
                        end else begin
                            deb_cnt_q <= '0;
                            col_idx_q <= col_idx_q + 1'b1;
                            state_q   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (row_s_q == ROW_IDLE) begin
                            if (rel_cnt_q == DEB_W'(DEBOUNCE_SCANS - 1)) begin
                                onehot_q  <= '0;
                                held_q    <= 1'b0;
                                rel_cnt_q <= '0;
                                col_idx_q <= col_idx_q + 1'b1;
                                state_q   <= SCAN;
                            end else begin
                                rel_cnt_q <= rel_cnt_q + 1'b1;
                            end
                        end else begin
                            rel_cnt_q <= '0;
                        end
`ifdef KEY_REPEAT_EN
                        if (!row_s_q[code_q[CODE_W-1 -: ROW_W]]) begin
                            if (rpt_cnt_q == rpt_last) begin
                                valid_q     <= 1'b1;
                                rpt_cnt_q   <= '0;
                                rpt_phase_q <= 1'b1;
                            end else begin
                                rpt_cnt_q <= rpt_cnt_q + 1'b1;
                            end
                        end else begin
                            rpt_cnt_q   <= '0;
                            rpt_phase_q <= 1'b0;
                        end
`endif
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign col_n     = ~(KP_COLS'(1) << col_idx_q);
    assign onehot    = onehot_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for a 4x4 active-low matrix keypad. It drives the four column lines in rotation, samples the row lines, and debounces presses and releases. It delivers a 16-bit one-hot key code plus a single-cycle key_valid strobe to the downstream one-hot-to-binary encoder and display logic. It is the only agent that owns the keypad pins; the encoder only consumes its one-hot output.

Parameters:
SCAN_DIV, 50000, clk cycles per scan tick (column dwell time); minimum 2.
DEBOUNCE_SCANS, 10, consecutive matching scan ticks required to accept a press or a release; minimum 1.
REPEAT_DELAY, 50, scan ticks from accepted press to first auto-repeat (KEY_REPEAT_EN only).
REPEAT_RATE, 10, scan ticks between subsequent auto-repeats (KEY_REPEAT_EN only).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
row_n  in  4  keypad row inputs; active-low, externally pulled up, asynchronous to clk
col_n  out  4  keypad column drive; active-low one-cold
onehot  out  16  accepted key; bit index = row*4 + col; all-zero when no key is held
key_valid  out  1  one-cycle pulse when a key is accepted (and on each repeat)
key_held  out  1  high from the accepted press until the accepted release

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: col_n=4'b1110, onehot=0, key_valid=0, key_held=0, FSM=SCAN, col_idx=0, all counters 0.
  - Reset asserted mid-debounce or mid-hold aborts immediately to these values.
- Input sync: row_n passes through a 2-FF synchronizer (row_s). All decisions use row_s only.
- Tick: divider counts 0..SCAN_DIV-1. tick=1 for one clk when count==SCAN_DIV-1. Divider free-runs in every state.
- Column drive: col_n = ~(4'b0001 << col_idx). col_idx changes only on a tick and wraps 3->0.
- FSM, evaluated on tick only (all state holds between ticks):
  - SCAN:
    - row_s==4'hF: col_idx++.
    - Exactly one row low: capture row_idx and col_idx into code; clear deb_cnt; go to DEBOUNCE; col_idx frozen.
    - Two or more rows low (ghost/multi-press): ignore; col_idx++.
  - DEBOUNCE:
    - row_s equals the captured pattern: deb_cnt++.
    - When deb_cnt reaches DEBOUNCE_SCANS: onehot <= 1<<code; key_held <= 1; key_valid pulses for one clk on the same edge; go to HELD.
    - Any mismatch: clear deb_cnt; col_idx++; go to SCAN.
  - HELD: col_idx frozen.
    - row_s==4'hF: rel_cnt++. Anything else clears rel_cnt, including additional keys, which are ignored.
    - When rel_cnt reaches DEBOUNCE_SCANS: onehot <= 0; key_held <= 0; col_idx++; go to SCAN.
- Latency: a press stable from tick T is accepted on the edge of tick T+DEBOUNCE_SCANS, plus 2 clk of sync delay.
- key_valid is never asserted outside the acceptance or repeat edges. onehot changes only on acceptance or release.

Optional Feature:
KEY_REPEAT_EN
- Defined: in HELD, a repeat counter counts ticks while the key stays pressed. key_valid re-pulses at tick REPEAT_DELAY after acceptance, then every REPEAT_RATE ticks. onehot is unchanged. Any non-pressed tick restarts the repeat counter.
- Undefined: exactly one key_valid per accepted press; no repeat logic is synthesized.

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, HELD}
  - KP_ROWS=4, KP_COLS=4, KP_KEYS=16
  - localparam widths for col_idx (2) and code (4)
  - ROW_IDLE=4'hF
- Sub-module scan_tick_gen: the SCAN_DIV divider with tick output, reused by the display multiplexer.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Reset: hold rst_n=0, toggle clk -> col_n=4'b1110, onehot=0, key_valid=0. Release -> col_n rotates 1110,1101,1011,0111,1110 every 4 clk.
- Clean press: row_n[2]=0 whenever col_n[1]=0 (key row2,col1) -> after 3 matching ticks, onehot=16'h0200 with one key_valid pulse and key_held=1. Release -> after 3 idle ticks, onehot=0 and key_held=0.
- Bounce: press row1,col3 for 1 tick then release -> no key_valid, FSM back in SCAN, col_idx advances to 0.
- Multi-press: rows 0 and 3 low on col0 -> ignored, scanning continues, no key_valid.
- Second key while held: hold key 0x0008, then add another key -> onehot stays 16'h0008, no extra key_valid. Release both -> onehot=0.
- KEY_REPEAT_EN with REPEAT_DELAY=5, REPEAT_RATE=2: hold one key for 12 ticks -> key_valid at acceptance, then ticks +5, +7, +9, +11.
